// File: rtl/cpu_bus_pkg.sv
// Shared CPU bus definitions: FSM state encoding, destination select width and codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_bus_pkg;

    localparam int SEL_W   = 2;
    localparam int NUM_DST = 4;

    // Same encoding as the 4:1 source select on the read side.
    localparam logic [SEL_W-1:0] DST_DMEM = 2'b00;
    localparam logic [SEL_W-1:0] DST_IO   = 2'b01;
    localparam logic [SEL_W-1:0] DST_SP0  = 2'b10;
    localparam logic [SEL_W-1:0] DST_SP1  = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Destination code to one-hot write strobe.
    function automatic logic [NUM_DST-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
        return NUM_DST'(1) << sel;
    endfunction

endpackage

// File: rtl/busy_timer.sv
// Wait-cycle counter for a pending write; flags the last permitted BUSY cycle.
// Latency: expired is combinational from the count register; clr/en act at the next edge.
// Backpressure: none; counts whenever en is high, clr has priority.
//
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   clr         zero the count (asserted when a request is accepted)
//   en          advance the count by one
//   expired     count has reached TIMEOUT-1; never asserted when TIMEOUT==0
module busy_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            // With TIMEOUT==0 the count simply wraps; expired stays low regardless.
            r_count <= r_count + CW'(1);
        end
    end

    assign expired = (TIMEOUT != 0) && (r_count == LAST);

endmodule

// File: rtl/store_demux4.sv
// Routes one CPU write to one of four destinations and holds it until ack or timeout.
// Latency: accept at edge N -> dst_valid in N+1; ack at edge M -> done in M+1 (2-cycle minimum).
// Backpressure: req_ready low while a write is outstanding; new requests wait in the CPU.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   req_valid/req_ready             CPU request handshake
//   req_sel, req_addr, req_data     destination code, address, data
//   dst_valid[3:0]                  one-hot strobe to destination i
//   dst_addr, dst_data              registered address/data shared by all destinations
//   dst_ack[3:0]                    per-destination acknowledge
//   done, err                       one-cycle completion / timeout pulses
module store_demux4
    import cpu_bus_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [SEL_W-1:0]   req_sel,
    input  logic [AW-1:0]      req_addr,
    input  logic [WIDTH-1:0]   req_data,
    output logic [NUM_DST-1:0] dst_valid,
    output logic [AW-1:0]      dst_addr,
    output logic [WIDTH-1:0]   dst_data,
    input  logic [NUM_DST-1:0] dst_ack,
    output logic               done,
    output logic               err
);

    state_t               r_state;
    logic [SEL_W-1:0]     r_sel;
    logic [NUM_DST-1:0]   r_dst_valid;
    logic [AW-1:0]        r_dst_addr;
    logic [WIDTH-1:0]     r_dst_data;
    logic                 r_done;
    logic                 r_err;

    state_t               w_state_nxt;
    logic [NUM_DST-1:0]   w_dst_valid_nxt;
    logic                 w_done_nxt;
    logic                 w_err_nxt;
    logic                 w_capture;
    logic                 w_tmr_en;
    logic                 w_expired;
    logic                 w_ack;

    // Only the selected destination's ack counts; stray acks are ignored.
    assign w_ack     = dst_ack[r_sel];
    assign req_ready = (r_state == IDLE);

    busy_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_busy_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (w_capture),
        .en      (w_tmr_en),
        .expired (w_expired)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_dst_valid_nxt = r_dst_valid;
        w_done_nxt      = 1'b0;
        w_err_nxt       = 1'b0;
        w_capture       = 1'b0;
        w_tmr_en        = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_capture       = 1'b1;
                    w_dst_valid_nxt = sel_onehot(req_sel);
                    w_state_nxt     = BUSY;
                end
            end
            BUSY: begin
                // Ack is checked before expiry so a last-cycle ack still completes cleanly.
                if (w_ack) begin
                    w_dst_valid_nxt = '0;
                    w_done_nxt      = 1'b1;
                    w_state_nxt     = IDLE;
                end else if (w_expired) begin
                    w_dst_valid_nxt = '0;
                    w_err_nxt       = 1'b1;
                    w_state_nxt     = IDLE;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end
            default: begin
                w_dst_valid_nxt = '0;
                w_state_nxt     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_sel       <= '0;
            r_dst_valid <= '0;
            r_dst_addr  <= '0;
            r_dst_data  <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_dst_valid <= w_dst_valid_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
            if (w_capture) begin
                r_sel      <= req_sel;
                r_dst_addr <= req_addr;
                r_dst_data <= req_data;
            end
        end
    end

    assign dst_valid = r_dst_valid;
    assign dst_addr  = r_dst_addr;
    assign dst_data  = r_dst_data;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_store_demux4.sv
// Bench for store_demux4 with TIMEOUT=4: cycle-by-cycle vector table plus a timeout sequence.
// Latency: each vector applies inputs, takes one rising edge, then compares outputs 1ns later.
// Backpressure: vectors hold req_valid high across BUSY to confirm requests wait for req_ready.
module tb_store_demux4;
    import cpu_bus_pkg::*;

    localparam int WIDTH   = 32;
    localparam int AW      = 32;
    localparam int TIMEOUT = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               req_valid;
    logic               req_ready;
    logic [SEL_W-1:0]   req_sel;
    logic [AW-1:0]      req_addr;
    logic [WIDTH-1:0]   req_data;
    logic [NUM_DST-1:0] dst_valid;
    logic [AW-1:0]      dst_addr;
    logic [WIDTH-1:0]   dst_data;
    logic [NUM_DST-1:0] dst_ack;
    logic               done;
    logic               err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    store_demux4 #(
        .WIDTH   (WIDTH),
        .AW      (AW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_sel   (req_sel),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .dst_valid (dst_valid),
        .dst_addr  (dst_addr),
        .dst_data  (dst_data),
        .dst_ack   (dst_ack),
        .done      (done),
        .err       (err)
    );

    typedef struct {
        string              name;
        logic               rst_n;
        logic               req_valid;
        logic [SEL_W-1:0]   req_sel;
        logic [AW-1:0]      req_addr;
        logic [WIDTH-1:0]   req_data;
        logic [NUM_DST-1:0] dst_ack;
        logic               exp_ready;
        logic [NUM_DST-1:0] exp_valid;
        logic [AW-1:0]      exp_addr;
        logic [WIDTH-1:0]   exp_data;
        logic               exp_done;
        logic               exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string name, input logic r, input logic v, input logic [1:0] s,
                       input logic [31:0] a, input logic [31:0] d, input logic [3:0] ack,
                       input logic e_rdy, input logic [3:0] e_vld, input logic [31:0] e_a,
                       input logic [31:0] e_d, input logic e_done, input logic e_err);
        vec_t t;
        t.name = name; t.rst_n = r; t.req_valid = v; t.req_sel = s; t.req_addr = a;
        t.req_data = d; t.dst_ack = ack; t.exp_ready = e_rdy; t.exp_valid = e_vld;
        t.exp_addr = e_a; t.exp_data = e_d; t.exp_done = e_done; t.exp_err = e_err;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int v_cycles;
        bit seen_err;
        bit seen_done;

        rst_n = 1'b0; req_valid = 1'b0; req_sel = '0; req_addr = '0; req_data = '0; dst_ack = '0;

        //   name          rst v  sel       addr      data          ack      rdy vld      addr      data          dn er
        // Reset held with req_valid high: nothing is accepted.
        add("reset0",      0, 1, DST_IO,   32'h11,   32'h22,       4'b0000, 1, 4'b0000, 32'h0,    32'h0,        0, 0);
        add("reset1",      0, 1, DST_IO,   32'h11,   32'h22,       4'b0000, 1, 4'b0000, 32'h0,    32'h0,        0, 0);
        add("reset2",      0, 1, DST_IO,   32'h11,   32'h22,       4'b0000, 1, 4'b0000, 32'h0,    32'h0,        0, 0);
        add("idle",        1, 0, DST_IO,   32'h11,   32'h22,       4'b0000, 1, 4'b0000, 32'h0,    32'h0,        0, 0);
        // Zero-wait write to d1 with ack already high.
        add("b_accept",    1, 1, DST_IO,   32'h10,   32'hDEADBEEF, 4'b0010, 0, 4'b0010, 32'h10,   32'hDEADBEEF, 0, 0);
        add("b_ack",       1, 0, DST_DMEM, 32'h0,    32'h0,        4'b0010, 1, 4'b0000, 32'h10,   32'hDEADBEEF, 1, 0);
        add("b_after",     1, 0, DST_DMEM, 32'h0,    32'h0,        4'b0000, 1, 4'b0000, 32'h10,   32'hDEADBEEF, 0, 0);
        // d2 with wait states, stray acks, and a competing request held on the bus.
        add("w_accept",    1, 1, DST_SP0,  32'h20,   32'h12345678, 4'b0000, 0, 4'b0100, 32'h20,   32'h12345678, 0, 0);
        add("w_wrong0",    1, 1, DST_DMEM, 32'h99,   32'h99,       4'b1011, 0, 4'b0100, 32'h20,   32'h12345678, 0, 0);
        add("w_wrong1",    1, 0, DST_DMEM, 32'h0,    32'h0,        4'b1011, 0, 4'b0100, 32'h20,   32'h12345678, 0, 0);
        add("w_ack",       1, 0, DST_DMEM, 32'h0,    32'h0,        4'b0100, 1, 4'b0000, 32'h20,   32'h12345678, 1, 0);
        add("w_after",     1, 0, DST_DMEM, 32'h0,    32'h0,        4'b0000, 1, 4'b0000, 32'h20,   32'h12345678, 0, 0);
        // d3 timeout: strobe high exactly 4 cycles, then err.
        add("t_accept",    1, 1, DST_SP1,  32'h30,   32'hCAFEF00D, 4'b0000, 0, 4'b1000, 32'h30,   32'hCAFEF00D, 0, 0);
        add("t_c1",        1, 0, DST_DMEM, 32'h0,    32'h0,        4'b0111, 0, 4'b1000, 32'h30,   32'hCAFEF00D, 0, 0);
        add("t_c2",        1, 0, DST_DMEM, 32'h0,    32'h0,        4'b0111, 0, 4'b1000, 32'h30,   32'hCAFEF00D, 0, 0);
        add("t_c3",        1, 0, DST_DMEM, 32'h0,    32'h0,        4'b0111, 0, 4'b1000, 32'h30,   32'hCAFEF00D, 0, 0);
        add("t_err",       1, 0, DST_DMEM, 32'h0,    32'h0,        4'b0000, 1, 4'b0000, 32'h30,   32'hCAFEF00D, 0, 1);
        add("t_after",     1, 0, DST_DMEM, 32'h0,    32'h0,        4'b0000, 1, 4'b0000, 32'h30,   32'hCAFEF00D, 0, 0);
        // d0 ack on the final timeout cycle: ack wins.
        add("c_accept",    1, 1, DST_DMEM, 32'h40,   32'h0BADF00D, 4'b0000, 0, 4'b0001, 32'h40,   32'h0BADF00D, 0, 0);
        add("c_c1",        1, 0, DST_DMEM, 32'h0,    32'h0,        4'b0000, 0, 4'b0001, 32'h40,   32'h0BADF00D, 0, 0);
        add("c_c2",        1, 0, DST_DMEM, 32'h0,    32'h0,        4'b0000, 0, 4'b0001, 32'h40,   32'h0BADF00D, 0, 0);
        add("c_c3",        1, 0, DST_DMEM, 32'h0,    32'h0,        4'b0000, 0, 4'b0001, 32'h40,   32'h0BADF00D, 0, 0);
        add("c_done",      1, 0, DST_DMEM, 32'h0,    32'h0,        4'b0001, 1, 4'b0000, 32'h40,   32'h0BADF00D, 1, 0);
        add("c_after",     1, 0, DST_DMEM, 32'h0,    32'h0,        4'b0000, 1, 4'b0000, 32'h40,   32'h0BADF00D, 0, 0);
        // Back-to-back with req_valid held: second request waits for req_ready.
        add("bb_acc0",     1, 1, DST_DMEM, 32'h50,   32'h1,        4'b0000, 0, 4'b0001, 32'h50,   32'h1,        0, 0);
        add("bb_ack0",     1, 1, DST_SP1,  32'h60,   32'h2,        4'b0001, 1, 4'b0000, 32'h50,   32'h1,        1, 0);
        add("bb_acc1",     1, 1, DST_SP1,  32'h60,   32'h2,        4'b0000, 0, 4'b1000, 32'h60,   32'h2,        0, 0);
        add("bb_ack1",     1, 0, DST_DMEM, 32'h0,    32'h0,        4'b1000, 1, 4'b0000, 32'h60,   32'h2,        1, 0);
        add("bb_after",    1, 0, DST_DMEM, 32'h0,    32'h0,        4'b0000, 1, 4'b0000, 32'h60,   32'h2,        0, 0);
        // Reset while BUSY: request dropped, no pulse.
        add("r_accept",    1, 1, DST_IO,   32'h70,   32'h3,        4'b0000, 0, 4'b0010, 32'h70,   32'h3,        0, 0);
        add("r_reset",     0, 0, DST_DMEM, 32'h0,    32'h0,        4'b0010, 1, 4'b0000, 32'h0,    32'h0,        0, 0);
        add("r_after",     1, 0, DST_DMEM, 32'h0,    32'h0,        4'b0010, 1, 4'b0000, 32'h0,    32'h0,        0, 0);

        foreach (vecs[i]) begin
            rst_n     = vecs[i].rst_n;
            req_valid = vecs[i].req_valid;
            req_sel   = vecs[i].req_sel;
            req_addr  = vecs[i].req_addr;
            req_data  = vecs[i].req_data;
            dst_ack   = vecs[i].dst_ack;
            step();
            check({vecs[i].name, ".ready"}, 64'(req_ready), 64'(vecs[i].exp_ready));
            check({vecs[i].name, ".dst_valid"}, 64'(dst_valid), 64'(vecs[i].exp_valid));
            check({vecs[i].name, ".dst_addr"}, 64'(dst_addr), 64'(vecs[i].exp_addr));
            check({vecs[i].name, ".dst_data"}, 64'(dst_data), 64'(vecs[i].exp_data));
            check({vecs[i].name, ".done"}, 64'(done), 64'(vecs[i].exp_done));
            check({vecs[i].name, ".err"}, 64'(err), 64'(vecs[i].exp_err));
        end

        // Timeout measured with a bounded wait instead of fixed rows.
        rst_n = 1'b1; dst_ack = '0;
        req_valid = 1'b1; req_sel = DST_SP1; req_addr = 32'h80; req_data = 32'h4;
        step();
        req_valid = 1'b0;
        v_cycles = 0; seen_err = 1'b0; seen_done = 1'b0;
        for (int i = 0; i < 20 && !seen_err; i++) begin
            if (dst_valid == 4'b1000) v_cycles++;
            check("seq.onehot", 64'($onehot0(dst_valid)), 64'(1));
            step();
            if (err) seen_err = 1'b1;
            if (done) seen_done = 1'b1;
        end
        check("seq.err_seen", 64'(seen_err), 64'(1));
        check("seq.valid_cycles", 64'(v_cycles), 64'(TIMEOUT));
        check("seq.no_done", 64'(seen_done), 64'(0));
        check("seq.ready_with_err", 64'(req_ready), 64'(1));
        step();
        check("seq.err_one_cycle", 64'(err), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
